// File: rtl/perm_round_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// perm_round_sequencer_pkg
// Shared definitions for the permutation round sequencer:
//   - default round/step counts
//   - FSM state encoding
//   - registered control-output bundle and its per-state decode
// No ports (package).
// -----------------------------------------------------------------------------
package perm_round_sequencer_pkg;

    localparam int DEF_ROUNDS = 24;
    localparam int DEF_STEPS  = 5;
    localparam int DEF_BLK_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_REQUEST,
        S_LOAD,
        S_COMPUTE,
        S_INFORM,
        S_FINISH
    } state_t;

    typedef struct packed {
        logic ready;
        logic in_ready;
        logic ld_reg;
        logic sel_res;
        logic out_valid;
        logic done;
    } ctl_t;

    // Moore output decode; evaluated on the next state so the outputs can be
    // registered and line up with the state they belong to.
    function automatic ctl_t decode_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_IDLE:    c.ready     = 1'b1;
            S_REQUEST: c.in_ready  = 1'b1;
            S_LOAD:    c.ld_reg    = 1'b1;
            S_COMPUTE: begin
                c.ld_reg  = 1'b1;
                c.sel_res = 1'b1;
            end
            S_INFORM:  c.out_valid = 1'b1;
            S_FINISH:  c.done      = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/perm_round_sequencer_counter.sv
// -----------------------------------------------------------------------------
// perm_round_sequencer_counter
// Wrapping counter with a run-time terminal value.
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   clr   in   synchronous clear (priority over en)
//   en    in   advance by one; wraps to 0 after reaching last
//   last  in   terminal value (modulus - 1)
//   cnt   out  current count
//   co    out  high while cnt == last (wrap happens on the next enabled edge)
// -----------------------------------------------------------------------------
module perm_round_sequencer_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         co
);

    assign co = (cnt == last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= co ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/perm_round_sequencer.sv
// -----------------------------------------------------------------------------
// perm_round_sequencer
// Controller for the iterative permutation datapath. For each of cfgBlocks
// blocks: accept a block (inValid/inReady), run ROUNDS x STEPS datapath steps,
// then present the result (outValid/outAck). Pulses done when the whole
// message is finished; abort returns to Idle from any state.
//   clk        in   clock
//   rst        in   synchronous active-high reset (priority over abort)
//   start      in   begin a message (Idle only)
//   abort      in   return to Idle from any state
//   cfgBlocks  in   number of blocks, latched at start
//   inValid    in   source offers a block
//   inReady    out  controller accepts a block
//   ldReg      out  load the state register
//   selRes     out  0: load input block, 1: load step result
//   stepSel    out  datapath step within the round
//   roundIdx   out  round index (round-constant select)
//   blockIdx   out  0-based block index
//   outValid   out  result available
//   outAck     in   sink consumed the result
//   ready      out  controller idle
//   done       out  one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module perm_round_sequencer
    import perm_round_sequencer_pkg::*;
#(
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int STEPS  = DEF_STEPS,
    parameter int BLK_W  = DEF_BLK_W,
    localparam int RND_W  = $clog2(ROUNDS),
    localparam int STEP_W = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [BLK_W-1:0]  cfgBlocks,
    input  logic              inValid,
    output logic              inReady,
    output logic              ldReg,
    output logic              selRes,
    output logic [STEP_W-1:0] stepSel,
    output logic [RND_W-1:0]  roundIdx,
    output logic [BLK_W-1:0]  blockIdx,
    output logic              outValid,
    input  logic              outAck,
    output logic              ready,
    output logic              done
);

    state_t           state;
    state_t           nxt;
    ctl_t             ctl;
    logic [BLK_W-1:0] cfg_latched;
    logic             step_co;
    logic             round_co;
    logic             blk_co;
    logic             in_compute;

    assign in_compute = (state == S_COMPUTE);

    // Step and round counters only move in Compute; the final step wraps both
    // to zero on the same edge that leaves Compute, so they read 0 elsewhere.
    perm_round_sequencer_counter #(.W(STEP_W)) u_step (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort),
        .en   (in_compute),
        .last (STEP_W'(STEPS - 1)),
        .cnt  (stepSel),
        .co   (step_co)
    );

    perm_round_sequencer_counter #(.W(RND_W)) u_round (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort),
        .en   (in_compute && step_co),
        .last (RND_W'(ROUNDS - 1)),
        .cnt  (roundIdx),
        .co   (round_co)
    );

    // Block counter terminates at the latched count minus one. It is cleared
    // in Init and Finish so it starts each message at 0 and reads 0 in Idle.
    perm_round_sequencer_counter #(.W(BLK_W)) u_block (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort || state == S_INIT || state == S_FINISH),
        .en   (state == S_INFORM && outAck && !blk_co),
        .last (cfg_latched - BLK_W'(1)),
        .cnt  (blockIdx),
        .co   (blk_co)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (start) nxt = S_INIT;
            S_INIT:    nxt = (cfg_latched == '0) ? S_FINISH : S_REQUEST;
            S_REQUEST: if (inValid) nxt = S_LOAD;
            S_LOAD:    nxt = S_COMPUTE;
            S_COMPUTE: if (step_co && round_co) nxt = S_INFORM;
            S_INFORM:  if (outAck) nxt = blk_co ? S_FINISH : S_REQUEST;
            S_FINISH:  nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ctl         <= decode_ctl(S_IDLE);
            cfg_latched <= '0;
        end else begin
            state <= nxt;
            ctl   <= decode_ctl(nxt);
            if (state == S_IDLE && start && !abort) begin
                cfg_latched <= cfgBlocks;
            end
        end
    end

    assign ready    = ctl.ready;
    assign inReady  = ctl.in_ready;
    assign ldReg    = ctl.ld_reg;
    assign selRes   = ctl.sel_res;
    assign outValid = ctl.out_valid;
    assign done     = ctl.done;

endmodule

// File: tb/tb_perm_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_perm_round_sequencer
// Lock-step bench: drives whole messages cycle by cycle and compares every
// output against values computed from the protocol timeline (block k, compute
// cycle c -> step c % STEPS, round c / STEPS). Handshake delays, idle-time
// inValid/outAck noise, spurious start pulses and cfgBlocks changes after the
// latch are randomized.
// -----------------------------------------------------------------------------
module tb_perm_round_sequencer;

    localparam int ROUNDS = 24;
    localparam int STEPS  = 5;
    localparam int BLK_W  = 8;
    localparam int RND_W  = $clog2(ROUNDS);
    localparam int STEP_W = $clog2(STEPS);
    localparam int NCOMP  = ROUNDS * STEPS;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [BLK_W-1:0]  cfgBlocks;
    logic              inValid;
    logic              inReady;
    logic              ldReg;
    logic              selRes;
    logic [STEP_W-1:0] stepSel;
    logic [RND_W-1:0]  roundIdx;
    logic [BLK_W-1:0]  blockIdx;
    logic              outValid;
    logic              outAck;
    logic              ready;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    perm_round_sequencer #(
        .ROUNDS (ROUNDS),
        .STEPS  (STEPS),
        .BLK_W  (BLK_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfgBlocks (cfgBlocks),
        .inValid   (inValid),
        .inReady   (inReady),
        .ldReg     (ldReg),
        .selRes    (selRes),
        .stepSel   (stepSel),
        .roundIdx  (roundIdx),
        .blockIdx  (blockIdx),
        .outValid  (outValid),
        .outAck    (outAck),
        .ready     (ready),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_ready, input logic e_in_ready,
                            input logic e_ld, input logic e_sel, input logic e_out_valid,
                            input logic e_done);
        chk({tag, ".ready"},    32'(ready),    32'(e_ready));
        chk({tag, ".inReady"},  32'(inReady),  32'(e_in_ready));
        chk({tag, ".ldReg"},    32'(ldReg),    32'(e_ld));
        chk({tag, ".selRes"},   32'(selRes),   32'(e_sel));
        chk({tag, ".outValid"}, 32'(outValid), 32'(e_out_valid));
        chk({tag, ".done"},     32'(done),     32'(e_done));
    endtask

    task automatic chk_idx(input string tag, input int e_step, input int e_round, input int e_blk);
        chk({tag, ".stepSel"},  32'(stepSel),  e_step);
        chk({tag, ".roundIdx"}, 32'(roundIdx), e_round);
        chk({tag, ".blockIdx"}, 32'(blockIdx), e_blk);
    endtask

    task automatic check_idle(input string tag);
        chk_outs(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_idx(tag, 0, 0, 0);
    endtask

    // Runs one message from an Idle cycle. intr_kind: 0 none, 1 abort, 2 reset,
    // applied during block 0 at compute cycle intr_k.
    task automatic run_message(input int n, input int in_lo, input int in_hi,
                               input int ack_lo, input int ack_hi,
                               input int intr_kind, input int intr_k);
        int d;
        chk("pre.ready", 32'(ready), 1);
        start     = 1'b1;
        cfgBlocks = BLK_W'(n);
        step();
        start     = 1'b0;
        cfgBlocks = BLK_W'($urandom);
        chk_outs("init", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        if (n == 0) begin
            chk_outs("zero.finish", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
            check_idle("zero.idle");
            return;
        end
        for (int b = 0; b < n; b++) begin
            d = int'($urandom_range(in_hi, in_lo));
            for (int i = 0; i < d; i++) begin
                inValid = 1'b0;
                chk_outs("req.wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                chk_idx("req.wait", 0, 0, b);
                step();
            end
            inValid = 1'b1;
            chk_outs("req", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_idx("req", 0, 0, b);
            step();
            inValid = 1'($urandom_range(1, 0));
            chk_outs("load", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk_idx("load", 0, 0, b);
            step();
            for (int k = 0; k < NCOMP; k++) begin
                chk_outs("compute", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                chk_idx("compute", k % STEPS, k / STEPS, b);
                if (b == 0 && intr_kind != 0 && k == intr_k) begin
                    start   = 1'b0;
                    inValid = 1'b0;
                    outAck  = 1'b0;
                    if (intr_kind == 1) begin
                        abort = 1'b1;
                        step();
                        abort = 1'b0;
                        check_idle("abort.idle");
                        step();
                        check_idle("abort.idle2");
                    end else begin
                        rst = 1'b1;
                        step();
                        check_idle("rst.idle1");
                        step();
                        check_idle("rst.idle2");
                        rst = 1'b0;
                        step();
                        check_idle("rst.after");
                    end
                    return;
                end
                inValid   = 1'($urandom_range(1, 0));
                outAck    = 1'($urandom_range(1, 0));
                start     = 1'($urandom_range(1, 0));
                cfgBlocks = BLK_W'($urandom);
                step();
            end
            start   = 1'b0;
            inValid = 1'b0;
            outAck  = 1'b0;
            d = int'($urandom_range(ack_hi, ack_lo));
            for (int i = 0; i < d; i++) begin
                chk_outs("inform.wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                chk_idx("inform.wait", 0, 0, b);
                step();
            end
            outAck = 1'b1;
            chk_outs("inform", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk_idx("inform", 0, 0, b);
            step();
            outAck = 1'b0;
        end
        chk_outs("finish", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("finish.blockIdx", 32'(blockIdx), n - 1);
        step();
        check_idle("end.idle");
        step();
        check_idle("end.idle2");
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cfgBlocks = '0;
        inValid   = 1'b0;
        outAck    = 1'b0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("reset.released");

        // single block, source always ready
        run_message(1, 0, 0, 0, 0, 0, 0);
        // synchronous reset held two cycles in round 10
        run_message(1, 0, 0, 0, 0, 2, 10 * STEPS);
        // three blocks with source and sink backpressure
        run_message(3, 4, 4, 3, 3, 0, 0);
        // empty message
        run_message(0, 0, 0, 0, 0, 0, 0);
        // abort in round 10, then a clean single-block message
        run_message(1, 1, 2, 0, 1, 1, 10 * STEPS + 2);
        run_message(1, 0, 2, 0, 2, 0, 0);
        // randomized messages
        for (int m = 0; m < 4; m++) begin
            run_message(int'($urandom_range(4, 1)), 0, 5, 0, 5, 0, 0);
        end
        // abort on the very first compute cycle
        run_message(2, 0, 1, 0, 1, 1, 0);
        run_message(2, 0, 3, 0, 3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
